// File: rtl/assert_error_collector.sv
// assert_error_collector: timestamps per-source assertion failure pulses,
// arbitrates lowest-index-first and queues {id, stamp} records in a small
// FIFO drained through a valid/ready read port. Saturating totals of
// failures and dropped repeats are kept alongside.
module assert_error_collector #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] err_i,
    input  logic             clr_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [ID_W-1:0]  rd_id_o,
    output logic [TS_W-1:0]  rd_stamp_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] lost_count_o,
    output logic [ID_W-1:0]  last_id_o,
    output logic             last_valid_o,
    output logic [N_SRC-1:0] pend_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [TS_W-1:0]  stamp_q [N_SRC];
    logic [TS_W-1:0]  stamp_d [N_SRC];
    logic [ID_W-1:0]  fid_q [DEPTH];
    logic [ID_W-1:0]  fid_d [DEPTH];
    logic [TS_W-1:0]  fstamp_q [DEPTH];
    logic [TS_W-1:0]  fstamp_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, lost_cnt_q, lost_cnt_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic             last_valid_q, last_valid_d;

    logic             full, rd_valid, pop, push;
    logic [ID_W-1:0]  sel;
    logic [CNT_W:0]   err_inc, lost_inc, err_sum, lost_sum;

    // Next-state: arbitration, FIFO push/pop, capture, saturating counters, clear
    always_comb begin
        ts_d         = ts_q + 1'b1;
        pending_d    = pending_q;
        stamp_d      = stamp_q;
        fid_d        = fid_q;
        fstamp_d     = fstamp_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        last_id_d    = last_id_q;
        last_valid_d = last_valid_q;
        err_inc      = '0;
        lost_inc     = '0;

        full     = (cnt_q == (PTR_W+1)'(DEPTH));
        rd_valid = (cnt_q != '0);
        pop      = rd_valid && rd_ready_i;

        // Descending scan so the lowest pending index wins
        sel = '0;
        for (int unsigned k = N_SRC; k > 0; k--) begin
            if (pending_q[k-1]) sel = ID_W'(k-1);
        end
        push = (|pending_q) && (!full || pop);

        if (push) begin
            fid_d[wr_ptr_q]    = sel;
            fstamp_d[wr_ptr_q] = stamp_q[sel];
            wr_ptr_d           = wr_ptr_q + 1'b1;
            pending_d[sel]     = 1'b0;
            last_id_d          = sel;
            last_valid_d       = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;

        // A source being pushed this edge is free to recapture immediately
        for (int unsigned k = 0; k < N_SRC; k++) begin
            err_inc = err_inc + (CNT_W+1)'(err_i[k]);
            if (err_i[k]) begin
                if (!pending_q[k] || (push && (ID_W'(k) == sel))) begin
                    pending_d[k] = 1'b1;
                    stamp_d[k]   = ts_q;
                end else begin
                    lost_inc = lost_inc + 1'b1;
                end
            end
        end

        err_sum    = {1'b0, err_cnt_q} + err_inc;
        lost_sum   = {1'b0, lost_cnt_q} + lost_inc;
        err_cnt_d  = err_sum[CNT_W]  ? '1 : err_sum[CNT_W-1:0];
        lost_cnt_d = lost_sum[CNT_W] ? '1 : lost_sum[CNT_W-1:0];

        if (clr_i) begin
            ts_d         = '0;
            pending_d    = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            cnt_d        = '0;
            err_cnt_d    = '0;
            lost_cnt_d   = '0;
            last_id_d    = '0;
            last_valid_d = 1'b0;
            for (int unsigned k = 0; k < N_SRC; k++) stamp_d[k] = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fid_d[i]    = '0;
                fstamp_d[i] = '0;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q         <= '0;
            pending_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            err_cnt_q    <= '0;
            lost_cnt_q   <= '0;
            last_id_q    <= '0;
            last_valid_q <= 1'b0;
            for (int unsigned k = 0; k < N_SRC; k++) stamp_q[k] <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fid_q[i]    <= '0;
                fstamp_q[i] <= '0;
            end
        end else begin
            ts_q         <= ts_d;
            pending_q    <= pending_d;
            stamp_q      <= stamp_d;
            fid_q        <= fid_d;
            fstamp_q     <= fstamp_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            err_cnt_q    <= err_cnt_d;
            lost_cnt_q   <= lost_cnt_d;
            last_id_q    <= last_id_d;
            last_valid_q <= last_valid_d;
        end
    end

    // Head record is masked to zero whenever the FIFO is empty
    always_comb begin
        rd_valid_o   = rd_valid;
        rd_id_o      = rd_valid ? fid_q[rd_ptr_q]    : '0;
        rd_stamp_o   = rd_valid ? fstamp_q[rd_ptr_q] : '0;
        err_count_o  = err_cnt_q;
        lost_count_o = lost_cnt_q;
        last_id_o    = last_id_q;
        last_valid_o = last_valid_q;
        pend_o       = pending_q;
    end

endmodule

// File: tb/tb_assert_error_collector.sv
// Directed bench for assert_error_collector: single failure, simultaneous
// arbitration, full FIFO back-pressure, repeat loss, counter saturation,
// and clear / async reset in the middle of operation.
module tb_assert_error_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  err_i = '0;
    logic        clr_i = 1'b0;
    logic        rd_ready_i = 1'b0;
    logic        rd_valid_o;
    logic [2:0]  rd_id_o;
    logic [15:0] rd_stamp_o;
    logic [15:0] err_count_o, lost_count_o;
    logic [2:0]  last_id_o;
    logic        last_valid_o;
    logic [7:0]  pend_o;

    // Second instance with narrow counters for saturation
    logic [7:0]  s_err_i = '0;
    logic        s_rd_valid;
    logic [2:0]  s_rd_id, s_last_id;
    logic [15:0] s_rd_stamp;
    logic [3:0]  s_err_count, s_lost_count;
    logic        s_last_valid;
    logic [7:0]  s_pend;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    assert_error_collector #(.N_SRC(8), .DEPTH(4), .TS_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .err_i(err_i), .clr_i(clr_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_id_o(rd_id_o),
        .rd_stamp_o(rd_stamp_o), .err_count_o(err_count_o), .lost_count_o(lost_count_o),
        .last_id_o(last_id_o), .last_valid_o(last_valid_o), .pend_o(pend_o)
    );

    assert_error_collector #(.N_SRC(8), .DEPTH(4), .TS_W(16), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .err_i(s_err_i), .clr_i(1'b0),
        .rd_valid_o(s_rd_valid), .rd_ready_i(1'b0), .rd_id_o(s_rd_id),
        .rd_stamp_o(s_rd_stamp), .err_count_o(s_err_count), .lost_count_o(s_lost_count),
        .last_id_o(s_last_id), .last_valid_o(s_last_valid), .pend_o(s_pend)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"},  32'(rd_valid_o),   0);
        check({tag, ".id"},     32'(rd_id_o),      0);
        check({tag, ".stamp"},  32'(rd_stamp_o),   0);
        check({tag, ".errcnt"}, 32'(err_count_o),  0);
        check({tag, ".lost"},   32'(lost_count_o), 0);
        check({tag, ".last"},   32'(last_id_o),    0);
        check({tag, ".lastv"},  32'(last_valid_o), 0);
        check({tag, ".pend"},   32'(pend_o),       0);
    endtask

    // Loads records 0,1,2 (stamp 0) and leaves sources 3,4 pending
    task automatic load_three(input string tag);
        do_reset();
        rd_ready_i = 1'b0;
        err_i = 8'h1F;
        tick();
        err_i = '0;
        tick(3);
        check({tag, ".pend"},  32'(pend_o),     32'h18);
        check({tag, ".valid"}, 32'(rd_valid_o), 1);
    endtask

    initial begin
        logic [2:0] exp_ids [8];
        logic [15:0] exp_st [5];

        // Reset state
        #3;
        check_zero("rst");
        rst_n = 1'b1;

        // Single failure at ts=10
        do_reset();
        tick(10);
        err_i = 8'h04;
        tick();
        err_i = '0;
        check("single.valid0", 32'(rd_valid_o), 0);
        check("single.pend",   32'(pend_o), 32'h04);
        tick();
        check("single.valid1", 32'(rd_valid_o), 1);
        check("single.id",     32'(rd_id_o), 2);
        check("single.stamp",  32'(rd_stamp_o), 10);
        check("single.errcnt", 32'(err_count_o), 1);
        check("single.last",   32'(last_id_o), 2);
        check("single.lastv",  32'(last_valid_o), 1);
        check("single.lost",   32'(lost_count_o), 0);

        // Simultaneous failures at ts=5, reader always ready
        do_reset();
        tick(5);
        err_i = 8'h81;
        rd_ready_i = 1'b1;
        tick();
        err_i = '0;
        tick();
        check("simul.id0",    32'(rd_id_o), 0);
        check("simul.st0",    32'(rd_stamp_o), 5);
        check("simul.pend",   32'(pend_o), 32'h80);
        tick();
        check("simul.id1",    32'(rd_id_o), 7);
        check("simul.st1",    32'(rd_stamp_o), 5);
        check("simul.last",   32'(last_id_o), 7);
        check("simul.errcnt", 32'(err_count_o), 2);
        tick();
        check("simul.empty",  32'(rd_valid_o), 0);

        // Full FIFO: all eight fail at ts=0, reader stalled
        do_reset();
        rd_ready_i = 1'b0;
        err_i = 8'hFF;
        tick();
        err_i = '0;
        tick(6);
        check("full.pend",  32'(pend_o), 32'hF0);
        check("full.head",  32'(rd_id_o), 0);
        check("full.lost",  32'(lost_count_o), 0);
        check("full.errcnt", 32'(err_count_o), 8);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full.id%0d", i), 32'(rd_id_o), 32'(i));
            check($sformatf("full.st%0d", i), 32'(rd_stamp_o), 0);
            tick();
        end
        check("full.drained", 32'(rd_valid_o), 0);
        rd_ready_i = 1'b0;

        // Repeat loss: FIFO holds 0,1,2,4; source 3 fires three edges from ts=20
        do_reset();
        err_i = 8'h17;
        tick();
        err_i = '0;
        tick(4);
        tick(15);
        err_i = 8'h08;
        tick(3);
        err_i = '0;
        check("loss.pend",   32'(pend_o), 32'h08);
        check("loss.lost",   32'(lost_count_o), 2);
        check("loss.errcnt", 32'(err_count_o), 7);
        exp_ids[0] = 3'd0; exp_ids[1] = 3'd1; exp_ids[2] = 3'd2;
        exp_ids[3] = 3'd4; exp_ids[4] = 3'd3;
        exp_st[0] = 16'd0; exp_st[1] = 16'd0; exp_st[2] = 16'd0;
        exp_st[3] = 16'd0; exp_st[4] = 16'd20;
        rd_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("loss.id%0d", i), 32'(rd_id_o), 32'(exp_ids[i]));
            check($sformatf("loss.st%0d", i), 32'(rd_stamp_o), 32'(exp_st[i]));
            tick();
        end
        rd_ready_i = 1'b0;

        // Saturation with 4-bit counters: 10 edges of two failures each
        do_reset();
        s_err_i = 8'h03;
        tick(10);
        check("sat.cnt", 32'(s_err_count), 15);
        tick(2);
        s_err_i = '0;
        tick(2);
        check("sat.hold", 32'(s_err_count), 15);
        check("sat.lost", 32'(s_lost_count), 15);

        // Synchronous clear mid-operation overrides err_i and rd_ready_i
        load_three("clr.load");
        clr_i = 1'b1;
        err_i = 8'hFF;
        rd_ready_i = 1'b1;
        tick();
        clr_i = 1'b0;
        err_i = '0;
        rd_ready_i = 1'b0;
        check_zero("clr");
        err_i = 8'h01;
        tick();
        err_i = '0;
        tick();
        check("clr.next.valid", 32'(rd_valid_o), 1);
        check("clr.next.id",    32'(rd_id_o), 0);
        check("clr.next.stamp", 32'(rd_stamp_o), 0);

        // Async reset pulse between edges
        load_three("arst.load");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        rst_n = 1'b1;
        err_i = 8'h01;
        tick();
        err_i = '0;
        tick();
        check("arst.next.valid", 32'(rd_valid_o), 1);
        check("arst.next.id",    32'(rd_id_o), 0);
        check("arst.next.stamp", 32'(rd_stamp_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/assert_error_collector.md
Name: assert_error_collector

Overview:
- Collects per-assertion failure pulses, replacing ad-hoc action-block writes to shared errorId/errorCount variables with a deterministic, ordered error log.
- Each source line is one assertion's failure report; the block timestamps it, arbitrates simultaneous failures lowest-index-first, and queues {id, stamp} records.
- The queue is drained through a valid/ready read port.
- Sits beside the assertion layer in verification/debug builds; the reader is a scoreboard, a CSR bridge, or a trace port.

Parameters:
- N_SRC, 8, number of failure sources; ID_W = $clog2(N_SRC).
- DEPTH, 4, record FIFO depth (power of 2, ≥2).
- TS_W, 16, timestamp width.
- CNT_W, 16, width of the saturating counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- err_i  in  N_SRC  per-source failure pulse, sampled every edge.
- clr_i  in  1  synchronous clear of all state.
- rd_valid_o  out  1  FIFO head record available.
- rd_ready_i  in  1  reader accepts head.
- rd_id_o  out  ID_W  head source index.
- rd_stamp_o  out  TS_W  head timestamp.
- err_count_o  out  CNT_W  saturating total of asserted err_i bits.
- lost_count_o  out  CNT_W  saturating count of dropped repeat events.
- last_id_o  out  ID_W  id of most recently queued record.
- last_valid_o  out  1  last_id_o meaningful.
- pend_o  out  N_SRC  captured-but-unqueued sources.

Behaviour:
- Reset (rst_n=0, async): ts, pending, FIFO, counters, last_id_o and last_valid_o all go to 0. rd_valid_o=0.
- ts: free-running, +1 per edge, wraps modulo 2^TS_W.
- Capture, evaluated per source k at each edge:
  - err_i[k]=1 with pending[k]=0, or with k being pushed this edge: set pending[k] and stamp[k] := current ts (the pre-increment value).
  - err_i[k]=1 with pending[k]=1 and k not pushed this edge: lost_count += 1. The original stamp is kept (first occurrence wins).
- Push:
  - Condition: any pending bit set and (FIFO not full, or FIFO full with a pop on the same edge).
  - Select the lowest-index pending k. Write {k, stamp[k]} to the FIFO, clear pending[k] unless it is recaptured per the capture rule, and set last_id_o=k, last_valid_o=1.
  - At most one push per edge.
- Latency: err_i sampled at edge E0 sets pending. It is pushed at E1 at the earliest, so rd_valid_o is high after E1.
- Pop: occurs on any edge where rd_valid_o and rd_ready_i are both high.
  - rd_id_o and rd_stamp_o show the head record and are stable while valid and not ready.
  - Both read 0 when rd_valid_o=0.
- Full FIFO: no push. Pending bits hold, and nothing is lost except repeats covered by the capture rule.
- err_count: += popcount(err_i) every edge, including lost events. Saturates at 2^CNT_W-1. lost_count saturates the same way.
- clr_i=1: next state equals the reset state. err_i and rd_ready_i are ignored on that edge; clr_i takes priority over all other events.
- Reset mid-operation: all records and pending bits are discarded immediately. No partial pop is visible.

Test Plan:
- Single failure: after reset, err_i=8'h04 on the edge where ts=10. Required:
  - Record {id=2, stamp=10}.
  - rd_valid_o rises one edge after capture.
  - err_count=1, last_id=2, lost=0.
- Simultaneous failures: err_i=8'h81 at ts=5, rd_ready_i=1. Required:
  - Records pop in order {0,5} then {7,5}.
  - err_count=2, last_id=7.
- Full FIFO: rd_ready_i=0, err_i=8'hFF for one edge. Required:
  - FIFO holds ids 0..3 and pend_o=8'hF0.
  - After raising rd_ready_i, ids 4..7 follow in order with identical stamps.
  - lost=0, err_count=8.
- Repeat loss: FIFO full, pending[3]=0, err_i[3] high for 3 edges starting at ts=20. Required:
  - pend_o[3]=1 and lost_count=2.
  - After draining, record {3,20} appears.
- Saturation: with CNT_W=4, assert err_i=8'h03 on 10 edges. Required: err_count_o=15 and holds at 15.
- Clear and reset mid-operation, each run separately after loading 3 records and 2 pending bits. Required:
  - clr_i for one edge, or an async rst_n pulse between edges, leaves every output 0 immediately after.
  - The next single failure is stamped at ts=0.
